// File: rtl/ysyx_pkg.sv
// Shared types and constants for the ysyx multi-cycle sequencer.
package ysyx_pkg;

    localparam int STATE_W = 3;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [STATE_W-1:0] {
        ST_RESET      = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_MEM_REQ    = 3'd4,
        ST_MEM_WAIT   = 3'd5,
        ST_WB         = 3'd6,
        ST_HALT_ERR   = 3'd7
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // States in which the sequencer is waiting on a memory handshake.
    function automatic logic is_handshake(state_t s);
        return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
               (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/ysyx_mc_ctrl_if.sv
// Instruction and data memory handshake bundle for the sequencer.
interface ysyx_mc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic             ifu_rsp_valid;
    logic [31:0]      ifu_rsp_data;
    logic             ifu_rsp_err;

    logic             lsu_req_valid;
    logic             lsu_req_we;
    logic             lsu_req_ready;
    logic             lsu_rsp_valid;
    logic [WIDTH-1:0] lsu_rsp_data;
    logic             lsu_rsp_err;

    // Sequencer side.
    modport master (
        output ifu_req_valid,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_req_we,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err
    );

    // Memory side.
    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_req_we,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err
    );
endinterface

// File: rtl/ysyx_wdt.sv
// Handshake watchdog: counts cycles spent in one waiting state and flags
// expiry on the TIMEOUT-th cycle. TIMEOUT=0 removes the counter entirely.
module ysyx_wdt #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, restart, count_en};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] cnt_reg;

            // Cleared on every state change; only advances while waiting.
            always_ff @(posedge clk) begin
                if (rst || restart) begin
                    cnt_reg <= '0;
                end else if (count_en) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // The current cycle is the TIMEOUT-th one spent waiting.
            assign expired = count_en && (cnt_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/ysyx_mc_ctrl.sv
// Multi-cycle sequencer: fetch / exec / mem / writeback FSM with
// valid-ready memory handshakes, commit strobes, counters and watchdog.
module ysyx_mc_ctrl
    import ysyx_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 64,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_mc_ctrl_if.master       bus,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_rd_we,
    input  logic                 dec_csr_we,
    output logic [31:0]          inst,
    output logic [WIDTH-1:0]     load_data,
    output logic                 pc_we,
    output logic                 rf_we,
    output logic                 csr_we,
    output logic                 commit,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    state_t                 state_reg, state_next;
    logic [31:0]            inst_reg;
    logic [WIDTH-1:0]       load_data_reg;
    logic [CNT_WIDTH-1:0]   cycle_cnt_reg;
    logic [CNT_WIDTH-1:0]   instret_cnt_reg;
    logic                   wdt_expired;

    ysyx_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .restart  (state_next != state_reg),
        .count_en (is_handshake(state_reg)),
        .expired  (wdt_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, handshake requests and writeback strobes. A completing
    // handshake wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_next        = state_reg;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_we    = 1'b0;
        pc_we             = 1'b0;
        rf_we             = 1'b0;
        csr_we            = 1'b0;
        commit            = 1'b0;
        case (state_reg)
            ST_RESET: state_next = ST_FETCH_REQ;
            ST_FETCH_REQ: begin
                bus.ifu_req_valid = 1'b1;
                if (bus.ifu_req_ready)  state_next = ST_FETCH_WAIT;
                else if (wdt_expired)   state_next = ST_HALT_ERR;
            end
            ST_FETCH_WAIT: begin
                if (bus.ifu_rsp_valid)  state_next = bus.ifu_rsp_err ? ST_HALT_ERR : ST_EXEC;
                else if (wdt_expired)   state_next = ST_HALT_ERR;
            end
            ST_EXEC: state_next = (dec_is_load || dec_is_store) ? ST_MEM_REQ : ST_WB;
            ST_MEM_REQ: begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_req_we    = dec_is_store;
                if (bus.lsu_req_ready)  state_next = ST_MEM_WAIT;
                else if (wdt_expired)   state_next = ST_HALT_ERR;
            end
            ST_MEM_WAIT: begin
                if (bus.lsu_rsp_err)        state_next = ST_HALT_ERR;
                else if (bus.lsu_rsp_valid) state_next = ST_WB;
                else if (wdt_expired)       state_next = ST_HALT_ERR;
            end
            ST_WB: begin
                pc_we      = 1'b1;
                rf_we      = dec_rd_we;
                csr_we     = dec_csr_we;
                commit     = 1'b1;
                state_next = ST_FETCH_REQ;
            end
            ST_HALT_ERR: state_next = ST_HALT_ERR;
            default:     state_next = ST_RESET;
        endcase
    end

    // Instruction / load-data capture and the two performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_reg        <= '0;
            load_data_reg   <= '0;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + CNT_WIDTH'(1);
            if (state_reg == ST_FETCH_WAIT && bus.ifu_rsp_valid && !bus.ifu_rsp_err) begin
                inst_reg <= bus.ifu_rsp_data;
            end
            if (state_reg == ST_MEM_WAIT && bus.lsu_rsp_valid && !bus.lsu_rsp_err && dec_is_load) begin
                load_data_reg <= bus.lsu_rsp_data;
            end
            if (state_reg == ST_WB) begin
                instret_cnt_reg <= instret_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign inst        = inst_reg;
    assign load_data   = load_data_reg;
    assign err         = (state_reg == ST_HALT_ERR);
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_ysyx_mc_ctrl.sv
// Directed testbench for ysyx_mc_ctrl with a configurable-latency memory.
module tb_ysyx_mc_ctrl;
    import ysyx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_mc_ctrl_if #(.WIDTH(32)) mb ();

    logic        dec_is_load  = 1'b0;
    logic        dec_is_store = 1'b0;
    logic        dec_rd_we    = 1'b0;
    logic        dec_csr_we   = 1'b0;
    logic [31:0] inst, load_data;
    logic        pc_we, rf_we, csr_we, commit, err;
    logic [63:0] cycle_cnt, instret_cnt;

    ysyx_mc_ctrl #(.WIDTH(32), .CNT_WIDTH(64), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (mb),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_rd_we    (dec_rd_we),
        .dec_csr_we   (dec_csr_we),
        .inst         (inst),
        .load_data    (load_data),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .csr_we       (csr_we),
        .commit       (commit),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model configuration (written by the main sequence only).
    int          ifu_stall = 0, ifu_lat = 1, lsu_stall = 0, lsu_lat = 1;
    logic [31:0] ifu_data = NOP_INST, lsu_data = 32'h0;
    logic        lsu_err_cfg = 1'b0;

    // Memory responder: ready after a stall, response ifu_lat/lsu_lat
    // cycles after acceptance. Pending responses survive reset on purpose.
    initial begin
        int  ifu_stall_left, ifu_pend, lsu_stall_left, lsu_pend;
        bit  ifu_acc, lsu_acc;
        ifu_stall_left = 0; ifu_pend = 0; lsu_stall_left = 0; lsu_pend = 0;
        mb.ifu_req_ready = 1'b0; mb.ifu_rsp_valid = 1'b0; mb.ifu_rsp_data = '0; mb.ifu_rsp_err = 1'b0;
        mb.lsu_req_ready = 1'b0; mb.lsu_rsp_valid = 1'b0; mb.lsu_rsp_data = '0; mb.lsu_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            ifu_acc = mb.ifu_req_valid && mb.ifu_req_ready;
            lsu_acc = mb.lsu_req_valid && mb.lsu_req_ready;
            @(posedge clk);
            #1;
            mb.ifu_rsp_valid = 1'b0; mb.ifu_rsp_err = 1'b0;
            mb.lsu_rsp_valid = 1'b0; mb.lsu_rsp_err = 1'b0;
            if (ifu_acc) begin ifu_pend = ifu_lat; ifu_stall_left = ifu_stall; end
            if (lsu_acc) begin lsu_pend = lsu_lat; lsu_stall_left = lsu_stall; end
            if (rst) begin ifu_stall_left = ifu_stall; lsu_stall_left = lsu_stall; end
            if (ifu_pend > 0) begin
                ifu_pend--;
                if (ifu_pend == 0) begin
                    mb.ifu_rsp_valid = 1'b1; mb.ifu_rsp_data = ifu_data;
                end
            end
            if (lsu_pend > 0) begin
                lsu_pend--;
                if (lsu_pend == 0) begin
                    mb.lsu_rsp_valid = 1'b1; mb.lsu_rsp_data = lsu_data; mb.lsu_rsp_err = lsu_err_cfg;
                end
            end
            mb.ifu_req_ready = 1'b0;
            if (mb.ifu_req_valid) begin
                if (ifu_stall_left > 0) ifu_stall_left--;
                else mb.ifu_req_ready = 1'b1;
            end
            mb.lsu_req_ready = 1'b0;
            if (mb.lsu_req_valid) begin
                if (lsu_stall_left > 0) lsu_stall_left--;
                else mb.lsu_req_ready = 1'b1;
            end
        end
    end

    // Reset for two edges, check reset values, release mid-cycle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_vec({tag, "_rst_ctl"}, {mb.ifu_req_valid, mb.lsu_req_valid, mb.lsu_req_we,
                  pc_we, rf_we, csr_we, commit, err}, 8'h00);
        check_vec({tag, "_rst_inst"}, inst, 0);
        check_vec({tag, "_rst_ld"}, load_data, 0);
        check_vec({tag, "_rst_cyc"}, cycle_cnt, 0);
        check_vec({tag, "_rst_ret"}, instret_cnt, 0);
        rst = 1'b0;
    endtask

    // Step until commit (left visible at the returning negedge) or budget out.
    task automatic wait_commit(input int max_cyc, output bit seen, output int ifu_c,
                               output int lsu_c, output bit we_seen, output int stray);
        seen = 0; ifu_c = 0; lsu_c = 0; we_seen = 0; stray = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (mb.ifu_req_valid) ifu_c++;
            if (mb.lsu_req_valid) begin lsu_c++; if (mb.lsu_req_we) we_seen = 1; end
            if (commit) seen = 1;
            else if (pc_we || rf_we || csr_we) stray++;
        end
    endtask

    // Step a fixed number of cycles, gathering commits/strobes and first err.
    task automatic run_cycles(input int n, output int commits, output int first_err,
                              output int ifu_c, output int strobes);
        commits = 0; first_err = -1; ifu_c = 0; strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (commit) commits++;
            if (pc_we || rf_we || csr_we) strobes++;
            if (mb.ifu_req_valid) ifu_c++;
            if (err && first_err < 0) first_err = int'(cycle_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen, we_seen;
        int ifu_c, lsu_c, stray, commits, first_err;
        bit found;

        // T1: ALU op, zero-wait memories.
        dec_rd_we = 1'b1; ifu_data = 32'h00100093;
        do_reset("t1");
        wait_commit(20, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t1_commit_seen", 64'(seen), 1);
        check_vec("t1_commit_cyc", cycle_cnt, 4);
        check_vec("t1_strobes", {pc_we, rf_we, csr_we}, 3'b110);
        check_vec("t1_inst", inst, 32'h00100093);
        check_vec("t1_stray", 64'(stray), 0);
        check_vec("t1_ifu_cyc", 64'(ifu_c), 1);
        check_vec("t1_lsu_cyc", 64'(lsu_c), 0);
        @(negedge clk);
        check_vec("t1_after", {commit, pc_we, rf_we}, 3'b000);
        check_vec("t1_instret", instret_cnt, 1);
        check_vec("t1_refetch", 64'(mb.ifu_req_valid), 1);
        $display("t1 alu: commit at cycle %0d", cycle_cnt - 1);

        // T2: fetch ready stalled 3 cycles, response 2 cycles after accept.
        ifu_stall = 3; ifu_lat = 2;
        do_reset("t2");
        wait_commit(30, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t2_commit_seen", 64'(seen), 1);
        check_vec("t2_commit_cyc", cycle_cnt, 8);
        check_vec("t2_req_held", 64'(ifu_c), 4);
        check_vec("t2_stray", 64'(stray), 0);
        $display("t2 slow fetch: commit at cycle %0d", cycle_cnt);
        ifu_stall = 0; ifu_lat = 1;

        // T3: load with one wait cycle.
        dec_is_load = 1'b1; dec_rd_we = 1'b1; lsu_lat = 2; lsu_data = 32'hDEADBEEF;
        ifu_data = 32'h00002083;
        do_reset("t3");
        wait_commit(30, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t3_commit_seen", 64'(seen), 1);
        check_vec("t3_commit_cyc", cycle_cnt, 7);
        check_vec("t3_lsu_cyc", 64'(lsu_c), 1);
        check_vec("t3_req_we", 64'(we_seen), 0);
        check_vec("t3_load_data", load_data, 32'hDEADBEEF);
        check_vec("t3_rf_we", 64'(rf_we), 1);
        $display("t3 load: load_data %h at cycle %0d", load_data, cycle_cnt);

        // T4: store, minimum latency.
        dec_is_load = 1'b0; dec_is_store = 1'b1; dec_rd_we = 1'b0; lsu_lat = 1;
        ifu_data = 32'h00102023;
        do_reset("t4");
        wait_commit(30, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t4_commit_seen", 64'(seen), 1);
        check_vec("t4_commit_cyc", cycle_cnt, 6);
        check_vec("t4_req_we", 64'(we_seen), 1);
        check_vec("t4_strobes", {pc_we, rf_we, csr_we}, 3'b100);
        check_vec("t4_load_data", load_data, 0);
        $display("t4 store: commit at cycle %0d", cycle_cnt);

        // T5: store bus error halts the core.
        lsu_err_cfg = 1'b1;
        do_reset("t5");
        run_cycles(10, commits, first_err, ifu_c, stray);
        check_vec("t5_commits", 64'(commits), 0);
        check_vec("t5_strobes", 64'(stray), 0);
        check_vec("t5_err_cyc", 64'(first_err), 6);
        check_vec("t5_err", 64'(err), 1);
        check_vec("t5_instret", instret_cnt, 0);
        check_vec("t5_cyc", cycle_cnt, 10);
        check_vec("t5_no_req", {mb.ifu_req_valid, mb.lsu_req_valid}, 2'b00);
        $display("t5 store error: err from cycle %0d", first_err);
        lsu_err_cfg = 1'b0;

        // T6: fetch never accepted, watchdog (TIMEOUT=8) fires; then recover.
        dec_is_store = 1'b0; dec_rd_we = 1'b1; ifu_stall = 1000;
        do_reset("t6");
        run_cycles(12, commits, first_err, ifu_c, stray);
        check_vec("t6_err_cyc", 64'(first_err), 9);
        check_vec("t6_req_cyc", 64'(ifu_c), 8);
        check_vec("t6_commits", 64'(commits), 0);
        $display("t6 watchdog: err from cycle %0d", first_err);
        ifu_stall = 0;
        do_reset("t6b");
        wait_commit(20, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t6b_commit_seen", 64'(seen), 1);
        check_vec("t6b_commit_cyc", cycle_cnt, 4);
        check_vec("t6b_err", 64'(err), 0);
        $display("t6b recovery: commit at cycle %0d", cycle_cnt);

        // T7: reset while in MEM_WAIT; late response must be ignored.
        dec_is_load = 1'b1; lsu_lat = 3; lsu_data = 32'hCAFE0001;
        do_reset("t7");
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mb.lsu_req_valid) found = 1;
        end
        check_vec("t7_memreq", 64'(found), 1);
        @(negedge clk);
        check_vec("t7_memwait_cyc", cycle_cnt, 5);
        rst = 1'b1;
        @(negedge clk);
        check_vec("t7_rst_ctl", {mb.ifu_req_valid, mb.lsu_req_valid, pc_we, rf_we, commit}, 5'b0);
        check_vec("t7_rst_cyc", cycle_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check_vec("t7_fetch_first", {mb.ifu_req_valid, mb.lsu_req_valid, commit}, 3'b100);
        @(negedge clk);
        check_vec("t7_ld_ignored", load_data, 0);
        wait_commit(20, seen, ifu_c, lsu_c, we_seen, stray);
        check_vec("t7_commit_seen", 64'(seen), 1);
        check_vec("t7_commit_cyc", cycle_cnt, 8);
        check_vec("t7_load_data", load_data, 32'hCAFE0001);
        check_vec("t7_instret", instret_cnt, 0);
        $display("t7 reset in mem_wait: commit at cycle %0d", cycle_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
